// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the bram front-end: data/block geometry, FSM states
// and the address-width helper used to size ports from NUM_BLOCKS.
package bram_ctrl_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 256;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  function automatic int unsigned addr_width(input int unsigned num_blocks);
    return 8 + $clog2(num_blocks);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping modulo N. Produces a one-hot grant plus the winner's index.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner,
  output logic          any_gnt
);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any_gnt && req[idx[PW-1:0]]) begin
        any_gnt             = 1'b1;
        winner              = idx[PW-1:0];
        gnt[idx[PW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one bram between NUM_REQ requesters: round-robin grant of one
// read or write per cycle, read-response routing, optional zero-fill.
module bram_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned NUM_BLOCKS     = 16,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW            = addr_width(NUM_BLOCKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AW-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ready,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [AW-1:0]             mem_rd_addr,
  output logic [AW-1:0]             mem_wr_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_valid_out
);

  localparam int unsigned DEPTH = BLOCK_WORDS * NUM_BLOCKS;
  localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rd_owner;
  logic            rd_owner_vld;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_winner;
  logic               arb_any;
  logic               grant;
  logic               grant_rd;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .winner  (arb_winner),
    .any_gnt (arb_any)
  );

  assign grant    = rst_n && (state == ST_RUN) && arb_any;
  assign grant_rd = grant && !req_we[arb_winner];

  always_comb begin
    state_nxt   = state;
    gnt         = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    ready       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_data_in = '0;

    // Everything visible is gated by rst_n so outputs go quiet in the same
    // cycle reset is asserted, not one edge later.
    if (rst_n) begin
      case (state)
        ST_CLEAR: begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = clr_cnt;
          if (clr_cnt == AW'(DEPTH - 1))
            state_nxt = ST_RUN;
        end
        ST_RUN: begin
          ready = 1'b1;
          if (arb_any) begin
            gnt = arb_gnt;
            if (req_we[arb_winner]) begin
              mem_wr_en   = 1'b1;
              mem_wr_addr = req_addr[arb_winner*AW +: AW];
              mem_data_in = req_wdata[arb_winner*DATA_W +: DATA_W];
            end else begin
              mem_rd_en   = 1'b1;
              mem_rd_addr = req_addr[arb_winner*AW +: AW];
            end
          end
        end
        default: state_nxt = ST_RUN;
      endcase

      rsp_data = mem_data_out;
      if (rd_owner_vld)
        rsp_valid[rd_owner] = mem_valid_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt      <= '0;
      rr_ptr       <= '0;
      rd_owner     <= '0;
      rd_owner_vld <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_owner_vld <= grant_rd;
      if (state == ST_CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
      if (grant)
        rr_ptr <= (32'(arb_winner) == NUM_REQ - 1) ? '0 : arb_winner + 1'b1;
      if (grant_rd)
        rd_owner <= arb_winner;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: one instance with zero-fill, one without, each
// attached to its own behavioural 1-cycle-latency bram.
module tb_bram_arbiter;

  localparam int unsigned NR    = 2;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_c, rst_r;
  logic [NR-1:0]     req, req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*16-1:0]  req_wdata;

  logic [NR-1:0] gnt_c, rspv_c, gnt_r, rspv_r;
  logic [15:0]   rspd_c, rspd_r, din_c, din_r;
  logic          ready_c, ready_r, rd_en_c, rd_en_r, wr_en_c, wr_en_r;
  logic [AW-1:0] rd_addr_c, wr_addr_c, rd_addr_r, wr_addr_r;
  logic [15:0]   dout_c = '0, dout_r = '0;
  logic          vo_c = 1'b0, vo_r = 1'b0;

  logic [15:0] mem_c [DEPTH];
  logic [15:0] mem_r [DEPTH];

  bram_arbiter #(.NUM_REQ(NR), .NUM_BLOCKS(1), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt_c), .rsp_valid(rspv_c), .rsp_data(rspd_c),
    .ready(ready_c), .mem_rd_en(rd_en_c), .mem_wr_en(wr_en_c),
    .mem_rd_addr(rd_addr_c), .mem_wr_addr(wr_addr_c), .mem_data_in(din_c),
    .mem_data_out(dout_c), .mem_valid_out(vo_c));

  bram_arbiter #(.NUM_REQ(NR), .NUM_BLOCKS(1), .CLEAR_ON_RESET(0)) dut_r (
    .clk(clk), .rst_n(rst_r), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt_r), .rsp_valid(rspv_r), .rsp_data(rspd_r),
    .ready(ready_r), .mem_rd_en(rd_en_r), .mem_wr_en(wr_en_r),
    .mem_rd_addr(rd_addr_r), .mem_wr_addr(wr_addr_r), .mem_data_in(din_r),
    .mem_data_out(dout_r), .mem_valid_out(vo_r));

  // Behavioural brams: synchronous write, registered read with valid strobe.
  always @(posedge clk) begin
    if (wr_en_c) mem_c[wr_addr_c] <= din_c;
    vo_c   <= rd_en_c;
    dout_c <= mem_c[rd_addr_c];
    if (wr_en_r) mem_r[wr_addr_r] <= din_r;
    vo_r   <= rd_en_r;
    dout_r <= mem_r[rd_addr_r];
  end

  int checks = 0;
  int failures = 0;
  int ptr_c = 0;
  logic [15:0] exp_mem [DEPTH];

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    req = r; req_we = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b01, 8'h05, 8'h06, 16'h1234, 16'h5678);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({ready_c, gnt_c, rspv_c, rd_en_c, wr_en_c} !== '0)
        begin failures++; $display("FAIL reset_c: got rdy=%b gnt=%b rsp=%b rd=%b wr=%b, want all 0", ready_c, gnt_c, rspv_c, rd_en_c, wr_en_c); end
      checks++;
      if ({ready_r, gnt_r, rspv_r, rd_en_r, wr_en_r} !== '0)
        begin failures++; $display("FAIL reset_r: got rdy=%b gnt=%b rsp=%b rd=%b wr=%b, want all 0", ready_r, gnt_r, rspv_r, rd_en_r, wr_en_r); end
      tick();
    end
  endtask

  task automatic test_clear_restart();
    drive(2'b01, 2'b00, 8'h33, 8'h00, 16'h0, 16'h0);
    rst_c = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en_c !== 1'b1 || wr_addr_c !== AW'(k) || din_c !== 16'h0 || gnt_c !== '0 || ready_c !== 1'b0 || rd_en_c !== 1'b0)
        begin failures++; $display("FAIL clear1[%0d]: wr=%b addr=%h din=%h gnt=%b rdy=%b rd=%b, want 1 %h 0000 00 0 0", k, wr_en_c, wr_addr_c, din_c, gnt_c, ready_c, rd_en_c, k); end
      tick();
    end
    rst_c = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_en_c !== 1'b0 || ready_c !== 1'b0)
      begin failures++; $display("FAIL clear_rst: wr=%b rdy=%b, want 0 0", wr_en_c, ready_c); end
    tick();
    rst_c = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en_c !== 1'b1 || wr_addr_c !== AW'(k) || din_c !== 16'h0 || gnt_c !== '0 || ready_c !== 1'b0 || rd_en_c !== 1'b0)
        begin failures++; $display("FAIL clear2[%0d]: wr=%b addr=%h din=%h gnt=%b rdy=%b rd=%b, want 1 %h 0000 00 0 0", k, wr_en_c, wr_addr_c, din_c, gnt_c, ready_c, rd_en_c, k); end
      tick();
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'h0;
    ptr_c = 0;
    @(negedge clk);
    checks++;
    if (ready_c !== 1'b1 || gnt_c !== 2'b01 || rd_en_c !== 1'b1 || rd_addr_c !== 8'h33 || wr_en_c !== 1'b0)
      begin failures++; $display("FAIL first_run: rdy=%b gnt=%b rd=%b addr=%h wr=%b, want 1 01 1 33 0", ready_c, gnt_c, rd_en_c, rd_addr_c, wr_en_c); end
    ptr_c = 1;
    tick();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_c !== 2'b01 || rspd_c !== 16'h0000)
      begin failures++; $display("FAIL first_rsp: rsp=%b data=%h, want 01 0000", rspv_c, rspd_c); end
    tick();
  endtask

  task automatic test_write_read();
    drive(2'b01, 2'b01, 8'h12, 8'h00, 16'hBEEF, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt_c !== 2'b01 || wr_en_c !== 1'b1 || wr_addr_c !== 8'h12 || din_c !== 16'hBEEF || rd_en_c !== 1'b0)
      begin failures++; $display("FAIL wr_gnt: gnt=%b wr=%b addr=%h din=%h rd=%b, want 01 1 12 beef 0", gnt_c, wr_en_c, wr_addr_c, din_c, rd_en_c); end
    exp_mem[8'h12] = 16'hBEEF;
    ptr_c = 1;
    tick();
    drive(2'b10, 2'b00, 8'h00, 8'h12, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt_c !== 2'b10 || rd_en_c !== 1'b1 || rd_addr_c !== 8'h12 || rspv_c !== 2'b00)
      begin failures++; $display("FAIL rd_gnt: gnt=%b rd=%b addr=%h rsp=%b, want 10 1 12 00", gnt_c, rd_en_c, rd_addr_c, rspv_c); end
    ptr_c = 0;
    tick();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_c !== 2'b10 || rspd_c !== 16'hBEEF)
      begin failures++; $display("FAIL raw_rsp: rsp=%b data=%h, want 10 beef", rspv_c, rspd_c); end
    tick();
    @(negedge clk);
    checks++;
    if (rspv_c !== 2'b00)
      begin failures++; $display("FAIL rsp_once: rsp=%b, want 00", rspv_c); end
  endtask

  task automatic test_back_to_back();
    int w, pw;
    logic [15:0] v [NR];
    v[0] = 16'h1111; v[1] = 16'h2222;
    for (int i = 0; i < NR; i++) begin
      drive(2'b01, 2'b01, AW'(i + 1), 8'h0, v[i], 16'h0);
      @(negedge clk);
      checks++;
      if (gnt_c !== 2'b01 || wr_en_c !== 1'b1 || wr_addr_c !== AW'(i + 1))
        begin failures++; $display("FAIL preload%0d: gnt=%b wr=%b addr=%h", i, gnt_c, wr_en_c, wr_addr_c); end
      exp_mem[i + 1] = v[i];
      ptr_c = 1;
      tick();
    end
    drive(2'b11, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0);
    pw = -1;
    for (int c = 0; c < 10; c++) begin
      w = rr_pick(2'b11, ptr_c);
      @(negedge clk);
      checks++;
      if (gnt_c !== NR'(1) << w || rd_en_c !== 1'b1 || rd_addr_c !== AW'(w + 1))
        begin failures++; $display("FAIL b2b_gnt[%0d]: gnt=%b rd=%b addr=%h, want %b 1 %h", c, gnt_c, rd_en_c, rd_addr_c, NR'(1) << w, w + 1); end
      if (pw >= 0) begin
        checks++;
        if (rspv_c !== NR'(1) << pw || rspd_c !== exp_mem[pw + 1])
          begin failures++; $display("FAIL b2b_rsp[%0d]: rsp=%b data=%h, want %b %h", c, rspv_c, rspd_c, NR'(1) << pw, exp_mem[pw + 1]); end
      end
      pw = w;
      ptr_c = (w + 1) % NR;
      tick();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_c !== NR'(1) << pw || rspd_c !== exp_mem[pw + 1])
      begin failures++; $display("FAIL b2b_last: rsp=%b data=%h", rspv_c, rspd_c); end
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] pv, pwe, eg;
    logic [AW-1:0] pa [NR];
    logic [15:0]   pd [NR];
    logic          prv, erd, ewr;
    int            w, pro;
    logic [15:0]   prd;
    pv = '0; pwe = '0; prv = 1'b0; pro = 0; prd = '0;
    for (int i = 0; i < NR; i++) begin pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = AW'($urandom_range(0, 15));
          pd[i]  = 16'($urandom);
        end
      drive(pv, pwe, pa[0], pa[1], pd[0], pd[1]);
      w = rr_pick(pv, ptr_c);
      eg  = (w < 0) ? '0 : NR'(1) << w;
      ewr = (w >= 0) && pwe[w];
      erd = (w >= 0) && !pwe[w];
      @(negedge clk);
      checks++;
      if (gnt_c !== eg || rd_en_c !== erd || wr_en_c !== ewr)
        begin failures++; $display("FAIL rnd_gnt[%0d]: gnt=%b rd=%b wr=%b, want %b %b %b", c, gnt_c, rd_en_c, wr_en_c, eg, erd, ewr); end
      if (ewr) begin
        checks++;
        if (wr_addr_c !== pa[w] || din_c !== pd[w])
          begin failures++; $display("FAIL rnd_wr[%0d]: addr=%h din=%h, want %h %h", c, wr_addr_c, din_c, pa[w], pd[w]); end
      end
      if (erd) begin
        checks++;
        if (rd_addr_c !== pa[w])
          begin failures++; $display("FAIL rnd_rd[%0d]: addr=%h, want %h", c, rd_addr_c, pa[w]); end
      end
      checks++;
      if (rspv_c !== (prv ? NR'(1) << pro : '0) || (prv && rspd_c !== prd))
        begin failures++; $display("FAIL rnd_rsp[%0d]: rsp=%b data=%h, want %b %h", c, rspv_c, rspd_c, prv ? NR'(1) << pro : '0, prd); end
      prv = 1'b0;
      if (w >= 0) begin
        if (pwe[w]) exp_mem[pa[w]] = pd[w];
        else begin prv = 1'b1; pro = w; prd = exp_mem[pa[w]]; end
        ptr_c = (w + 1) % NR;
        pv[w] = 1'b0;
      end
      tick();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_c !== (prv ? NR'(1) << pro : '0) || (prv && rspd_c !== prd))
      begin failures++; $display("FAIL rnd_tail: rsp=%b data=%h, want %h", rspv_c, rspd_c, prd); end
    tick();
  endtask

  task automatic test_reset_drop();
    rst_c = 1'b0;
    rst_r = 1'b1;
    drive(2'b01, 2'b01, 8'h12, 8'h00, 16'hBEEF, 16'h0);
    @(negedge clk);
    checks++;
    if (ready_r !== 1'b1 || gnt_r !== 2'b01 || wr_en_r !== 1'b1 || wr_addr_r !== 8'h12 || din_r !== 16'hBEEF)
      begin failures++; $display("FAIL nc_wr: rdy=%b gnt=%b wr=%b addr=%h din=%h, want 1 01 1 12 beef", ready_r, gnt_r, wr_en_r, wr_addr_r, din_r); end
    tick();
    drive(2'b01, 2'b00, 8'h12, 8'h00, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt_r !== 2'b01 || rd_en_r !== 1'b1)
      begin failures++; $display("FAIL nc_rd: gnt=%b rd=%b, want 01 1", gnt_r, rd_en_r); end
    tick();
    rst_r = 1'b0;
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_r !== 2'b00 || ready_r !== 1'b0)
      begin failures++; $display("FAIL nc_drop: rsp=%b rdy=%b, want 00 0", rspv_r, ready_r); end
    tick();
    rst_r = 1'b1;
    @(negedge clk);
    checks++;
    if (rspv_r !== 2'b00 || ready_r !== 1'b1)
      begin failures++; $display("FAIL nc_post: rsp=%b rdy=%b, want 00 1", rspv_r, ready_r); end
    tick();
    drive(2'b01, 2'b00, 8'h12, 8'h00, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt_r !== 2'b01 || rd_en_r !== 1'b1 || rd_addr_r !== 8'h12)
      begin failures++; $display("FAIL nc_rd2: gnt=%b rd=%b addr=%h, want 01 1 12", gnt_r, rd_en_r, rd_addr_r); end
    tick();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rspv_r !== 2'b01 || rspd_r !== 16'hBEEF)
      begin failures++; $display("FAIL nc_keep: rsp=%b data=%h, want 01 beef", rspv_r, rspd_r); end
    tick();
  endtask

  initial begin
    rst_c = 1'b0;
    rst_r = 1'b0;
    drive(2'b00, 2'b00, 8'h0, 8'h0, 16'h0, 16'h0);
    tick();
    test_reset();
    test_clear_restart();
    test_write_read();
    test_back_to_back();
    test_random();
    test_reset_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
